// File: rtl/uart_clock_link_host.sv
// Host-side initiator of the UART clock link: sends 'K'+DDMMYYYYHHMMSS set frames and parses
// "DD.MM.YYYY HH:MM:SS" replies to 'R'. Define CLK_LINK_RANGE_CHECK_EN to reject out-of-range fields.
module uart_clock_link_host #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int IDX_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_set_req,
    input  logic        i_get_req,
    input  logic [4:0]  i_set_date,
    input  logic [3:0]  i_set_month,
    input  logic [13:0] i_set_year,
    input  logic [4:0]  i_set_hour,
    input  logic [5:0]  i_set_min,
    input  logic [5:0]  i_set_sec,
    output logic [7:0]  o_tx_byte,
    output logic        o_flag_tx_byte,
    input  logic        i_tx_busy,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_flag_rx_byte,
    output logic        o_busy,
    output logic        o_set_done,
    output logic        o_get_valid,
    output logic        o_get_err,
    output logic [4:0]  o_get_date,
    output logic [3:0]  o_get_month,
    output logic [13:0] o_get_year,
    output logic [4:0]  o_get_hour,
    output logic [5:0]  o_get_min,
    output logic [5:0]  o_get_sec,
    output logic [2:0]  o_state
);

    // Handshake: o_flag_tx_byte is a one-cycle start strobe honoured only while i_tx_busy is low;
    // i_flag_rx_byte is a one-cycle valid strobe with no back-pressure, i_rx_byte valid in that cycle.
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_TX_ISSUE   = 3'd1;
    localparam logic [2:0] S_TX_GUARD   = 3'd2;
    localparam logic [2:0] S_TX_WAIT    = 3'd3;
    localparam logic [2:0] S_RX_COLLECT = 3'd4;
    localparam logic [2:0] S_FINISH     = 3'd5;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // get_err is registered, so fire one count early to land TIMEOUT_CYCLES cycles after the last byte.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

    logic [2:0]       r_state;
    logic             r_mode;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_rx_idx;
    logic [TMO_W-1:0] r_tmo;
    logic             r_fmt_err;

    logic [4:0]       r_set_date;
    logic [3:0]       r_set_month;
    logic [13:0]      r_set_year;
    logic [4:0]       r_set_hour;
    logic [5:0]       r_set_min;
    logic [5:0]       r_set_sec;

    logic [6:0]       r_acc_date;
    logic [6:0]       r_acc_month;
    logic [13:0]      r_acc_year;
    logic [6:0]       r_acc_hour;
    logic [6:0]       r_acc_min;
    logic [6:0]       r_acc_sec;

    logic [7:0]       r_tx_byte;
    logic             r_flag_tx;
    logic             r_busy;
    logic             r_set_done;
    logic             r_get_valid;
    logic             r_get_err;
    logic [4:0]       r_get_date;
    logic [3:0]       r_get_month;
    logic [13:0]      r_get_year;
    logic [4:0]       r_get_hour;
    logic [5:0]       r_get_min;
    logic [5:0]       r_get_sec;

    logic [7:0]       w_frame_byte;
    logic             w_rx_is_digit;
    logic [3:0]       w_rx_digit;
    logic             w_rx_ok;
    logic             w_range_bad;

    function automatic logic [7:0] asc_digit(input logic [13:0] v);
        return 8'h30 + 8'(v % 14'd10);
    endfunction

    always_comb begin
        w_frame_byte = 8'h00;
        case (r_idx)
            IDX_W'(0):  w_frame_byte = r_mode ? 8'h52 : 8'h4B;
            IDX_W'(1):  w_frame_byte = asc_digit(14'(r_set_date) / 14'd10);
            IDX_W'(2):  w_frame_byte = asc_digit(14'(r_set_date));
            IDX_W'(3):  w_frame_byte = asc_digit(14'(r_set_month) / 14'd10);
            IDX_W'(4):  w_frame_byte = asc_digit(14'(r_set_month));
            IDX_W'(5):  w_frame_byte = asc_digit(r_set_year / 14'd1000);
            IDX_W'(6):  w_frame_byte = asc_digit(r_set_year / 14'd100);
            IDX_W'(7):  w_frame_byte = asc_digit(r_set_year / 14'd10);
            IDX_W'(8):  w_frame_byte = asc_digit(r_set_year);
            IDX_W'(9):  w_frame_byte = asc_digit(14'(r_set_hour) / 14'd10);
            IDX_W'(10): w_frame_byte = asc_digit(14'(r_set_hour));
            IDX_W'(11): w_frame_byte = asc_digit(14'(r_set_min) / 14'd10);
            IDX_W'(12): w_frame_byte = asc_digit(14'(r_set_min));
            IDX_W'(13): w_frame_byte = asc_digit(14'(r_set_sec) / 14'd10);
            IDX_W'(14): w_frame_byte = asc_digit(14'(r_set_sec));
            default:    w_frame_byte = 8'h00;
        endcase
    end

    assign w_rx_is_digit = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h39);
    assign w_rx_digit    = i_rx_byte[3:0];

    always_comb begin
        w_rx_ok = w_rx_is_digit;
        case (r_rx_idx)
            IDX_W'(2), IDX_W'(5):   w_rx_ok = (i_rx_byte == 8'h2E);
            IDX_W'(10):             w_rx_ok = (i_rx_byte == 8'h20);
            IDX_W'(13), IDX_W'(16): w_rx_ok = (i_rx_byte == 8'h3A);
            default:                w_rx_ok = w_rx_is_digit;
        endcase
    end

`ifdef CLK_LINK_RANGE_CHECK_EN
    assign w_range_bad = (r_acc_date == 7'd0)  || (r_acc_date > 7'd31)  ||
                         (r_acc_month == 7'd0) || (r_acc_month > 7'd12) ||
                         (r_acc_hour > 7'd23)  || (r_acc_min > 7'd59)   ||
                         (r_acc_sec > 7'd59);
`else
    assign w_range_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_rx_idx    <= '0;
            r_tmo       <= '0;
            r_fmt_err   <= 1'b0;
            r_set_date  <= '0;
            r_set_month <= '0;
            r_set_year  <= '0;
            r_set_hour  <= '0;
            r_set_min   <= '0;
            r_set_sec   <= '0;
            r_acc_date  <= '0;
            r_acc_month <= '0;
            r_acc_year  <= '0;
            r_acc_hour  <= '0;
            r_acc_min   <= '0;
            r_acc_sec   <= '0;
            r_tx_byte   <= '0;
            r_flag_tx   <= 1'b0;
            r_busy      <= 1'b0;
            r_set_done  <= 1'b0;
            r_get_valid <= 1'b0;
            r_get_err   <= 1'b0;
            r_get_date  <= '0;
            r_get_month <= '0;
            r_get_year  <= '0;
            r_get_hour  <= '0;
            r_get_min   <= '0;
            r_get_sec   <= '0;
        end else begin
            r_flag_tx   <= 1'b0;
            r_set_done  <= 1'b0;
            r_get_valid <= 1'b0;
            r_get_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_set_req || i_get_req) begin
                        r_mode      <= ~i_set_req;
                        r_set_date  <= i_set_date;
                        r_set_month <= i_set_month;
                        r_set_year  <= (i_set_year > 14'd9999) ? 14'd9999 : i_set_year;
                        r_set_hour  <= i_set_hour;
                        r_set_min   <= i_set_min;
                        r_set_sec   <= i_set_sec;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_TX_ISSUE;
                    end
                end
                S_TX_ISSUE: begin
                    if (!i_tx_busy) begin
                        r_flag_tx <= 1'b1;
                        r_tx_byte <= w_frame_byte;
                        r_state   <= S_TX_GUARD;
                    end
                end
                // The UART raises tx_busy only one cycle after the strobe; skip that blind cycle.
                S_TX_GUARD: r_state <= S_TX_WAIT;
                S_TX_WAIT: begin
                    if (!i_tx_busy) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_mode) begin
                            r_rx_idx    <= '0;
                            r_tmo       <= '0;
                            r_fmt_err   <= 1'b0;
                            r_acc_date  <= '0;
                            r_acc_month <= '0;
                            r_acc_year  <= '0;
                            r_acc_hour  <= '0;
                            r_acc_min   <= '0;
                            r_acc_sec   <= '0;
                            r_state     <= S_RX_COLLECT;
                        end else if (r_idx == IDX_W'(14)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_TX_ISSUE;
                        end
                    end
                end
                S_RX_COLLECT: begin
                    if (i_flag_rx_byte) begin
                        r_tmo <= '0;
                        if (!w_rx_ok) r_fmt_err <= 1'b1;
                        if (w_rx_is_digit) begin
                            case (r_rx_idx)
                                IDX_W'(0), IDX_W'(1):
                                    r_acc_date <= r_acc_date * 7'd10 + {3'd0, w_rx_digit};
                                IDX_W'(3), IDX_W'(4):
                                    r_acc_month <= r_acc_month * 7'd10 + {3'd0, w_rx_digit};
                                IDX_W'(6), IDX_W'(7), IDX_W'(8), IDX_W'(9):
                                    r_acc_year <= r_acc_year * 14'd10 + {10'd0, w_rx_digit};
                                IDX_W'(11), IDX_W'(12):
                                    r_acc_hour <= r_acc_hour * 7'd10 + {3'd0, w_rx_digit};
                                IDX_W'(14), IDX_W'(15):
                                    r_acc_min <= r_acc_min * 7'd10 + {3'd0, w_rx_digit};
                                IDX_W'(17), IDX_W'(18):
                                    r_acc_sec <= r_acc_sec * 7'd10 + {3'd0, w_rx_digit};
                                default: ;
                            endcase
                        end
                        if (r_rx_idx == IDX_W'(18)) r_state <= S_FINISH;
                        else r_rx_idx <= r_rx_idx + IDX_W'(1);
                    end else if (r_tmo == TMO_LAST) begin
                        r_get_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_FINISH: begin
                    if (!r_mode) begin
                        r_set_done <= 1'b1;
                    end else if (r_fmt_err || w_range_bad) begin
                        r_get_err <= 1'b1;
                    end else begin
                        r_get_date  <= 5'(r_acc_date);
                        r_get_month <= 4'(r_acc_month);
                        r_get_year  <= r_acc_year;
                        r_get_hour  <= 5'(r_acc_hour);
                        r_get_min   <= 6'(r_acc_min);
                        r_get_sec   <= 6'(r_acc_sec);
                        r_get_valid <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_byte      = r_tx_byte;
    assign o_flag_tx_byte = r_flag_tx;
    assign o_busy         = r_busy;
    assign o_set_done     = r_set_done;
    assign o_get_valid    = r_get_valid;
    assign o_get_err      = r_get_err;
    assign o_get_date     = r_get_date;
    assign o_get_month    = r_get_month;
    assign o_get_year     = r_get_year;
    assign o_get_hour     = r_get_hour;
    assign o_get_min      = r_get_min;
    assign o_get_sec      = r_get_sec;
    assign o_state        = r_state;

endmodule

// File: tb/tb_uart_clock_link_host.sv
// Directed bench for uart_clock_link_host: set frames, reply parsing, malformed reply, timeout,
// simultaneous requests with year clamp, and reset mid-transaction.
module tb_uart_clock_link_host;

    localparam int TMO    = 100;
    localparam int TX_LEN = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_set_req = 1'b0;
    logic        i_get_req = 1'b0;
    logic [4:0]  i_set_date = '0;
    logic [3:0]  i_set_month = '0;
    logic [13:0] i_set_year = '0;
    logic [4:0]  i_set_hour = '0;
    logic [5:0]  i_set_min = '0;
    logic [5:0]  i_set_sec = '0;
    logic [7:0]  o_tx_byte;
    logic        o_flag_tx_byte;
    logic        tx_busy = 1'b0;
    logic [7:0]  i_rx_byte = '0;
    logic        i_flag_rx_byte = 1'b0;
    logic        o_busy, o_set_done, o_get_valid, o_get_err;
    logic [4:0]  o_get_date;
    logic [3:0]  o_get_month;
    logic [13:0] o_get_year;
    logic [4:0]  o_get_hour;
    logic [5:0]  o_get_min;
    logic [5:0]  o_get_sec;
    logic [2:0]  o_state;

    int n_cmp = 0;
    int n_fail = 0;
    int n_set_done = 0;
    int n_get_valid = 0;
    int n_get_err = 0;
    int tx_viol = 0;
    int tx_cnt = 0;
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    string reply;

    uart_clock_link_host #(.TIMEOUT_CYCLES(TMO), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_set_req(i_set_req), .i_get_req(i_get_req),
        .i_set_date(i_set_date), .i_set_month(i_set_month), .i_set_year(i_set_year),
        .i_set_hour(i_set_hour), .i_set_min(i_set_min), .i_set_sec(i_set_sec),
        .o_tx_byte(o_tx_byte), .o_flag_tx_byte(o_flag_tx_byte), .i_tx_busy(tx_busy),
        .i_rx_byte(i_rx_byte), .i_flag_rx_byte(i_flag_rx_byte),
        .o_busy(o_busy), .o_set_done(o_set_done), .o_get_valid(o_get_valid), .o_get_err(o_get_err),
        .o_get_date(o_get_date), .o_get_month(o_get_month), .o_get_year(o_get_year),
        .o_get_hour(o_get_hour), .o_get_min(o_get_min), .o_get_sec(o_get_sec),
        .o_state(o_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    // UART TX model and pulse monitors
    always @(posedge clk) begin
        if (o_set_done)  n_set_done++;
        if (o_get_valid) n_get_valid++;
        if (o_get_err)   n_get_err++;
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end else if (o_flag_tx_byte) begin
            if (tx_busy) tx_viol++;
            tx_log.push_back(o_tx_byte);
            tx_busy <= 1'b1;
            tx_cnt  <= TX_LEN;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_busy <= 1'b0;
        end
    end

    // Driver / checker tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        i_rx_byte      = b;
        i_flag_rx_byte = 1'b1;
        @(negedge clk);
        i_flag_rx_byte = 1'b0;
    endtask

    task automatic wait_flag(input int which, input int limit, input string tag);
        int   c   = 0;
        logic hit = 1'b0;
        while (!hit && c < limit) begin
            @(negedge clk);
            c++;
            case (which)
                0:       hit = o_set_done;
                1:       hit = o_get_valid;
                2:       hit = o_get_err;
                default: hit = (tx_log.size() >= 8);
            endcase
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int c = 0;
        while (o_state !== s && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(tag, {29'd0, o_state}, {29'd0, s});
    endtask

    task automatic check_tx(input string tag);
        logic [7:0] a;
        logic [7:0] e;
        int         i = 0;
        check({tag, "_len"}, tx_log.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (tx_log.size() > 0) ? tx_log.pop_front() : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'd0, a}, {24'd0, e});
            i++;
        end
        tx_log.delete();
    endtask

    task automatic push_frame(input logic [7:0] b0, input string digits);
        exp_q.push_back(b0);
        for (int i = 0; i < digits.len(); i++) exp_q.push_back(digits[i]);
    endtask

    task automatic pulse_set(input logic [4:0] d, input logic [3:0] mo, input logic [13:0] y,
                             input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                             input logic also_get);
        i_set_date = d; i_set_month = mo; i_set_year = y;
        i_set_hour = h; i_set_min = mi; i_set_sec = s;
        i_set_req = 1'b1;
        i_get_req = also_get;
        @(negedge clk);
        i_set_req = 1'b0;
        i_get_req = 1'b0;
    endtask

    task automatic pulse_get();
        i_get_req = 1'b1;
        @(negedge clk);
        i_get_req = 1'b0;
    endtask

    // Directed sequence
    initial begin
        int c;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_state", {29'd0, o_state}, 0);
        check("rst_flag_tx", {31'd0, o_flag_tx_byte}, 0);
        check("rst_get_year", {18'd0, o_get_year}, 0);
        check("rst_pulses", {29'd0, o_set_done, o_get_valid, o_get_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_flag_tx", {31'd0, o_flag_tx_byte}, 0);

        // Set 07/03/2025 14:05:09
        tx_log.delete();
        pulse_set(5'd7, 4'd3, 14'd2025, 5'd14, 6'd5, 6'd9, 1'b0);
        check("t1_busy_rise", {31'd0, o_busy}, 1);
        wait_flag(0, 1000, "t1_set_done_seen");
        @(negedge clk);
        check("t1_done_one_cycle", {31'd0, o_set_done}, 0);
        check("t1_busy_low", {31'd0, o_busy}, 0);
        check("t1_done_count", n_set_done, 1);
        check("t1_tx_overlap", tx_viol, 0);
        push_frame(8'h4B, "07032025140509");
        check_tx("t1_tx");

        // Request and good reply
        pulse_get();
        wait_state(3'd4, 500, "t2_rx_entry");
        reply = "31.12.1999 23:59:58";
        for (int i = 0; i < 18; i++) begin
            send_rx(reply[i]);
            repeat (2) @(negedge clk);
        end
        send_rx(reply[18]);
        check("t2_valid_t1", {31'd0, o_get_valid}, 0);
        @(negedge clk);
        check("t2_valid_t2", {31'd0, o_get_valid}, 1);
        check("t2_date", {27'd0, o_get_date}, 31);
        check("t2_month", {28'd0, o_get_month}, 12);
        check("t2_year", {18'd0, o_get_year}, 1999);
        check("t2_hour", {27'd0, o_get_hour}, 23);
        check("t2_min", {26'd0, o_get_min}, 59);
        check("t2_sec", {26'd0, o_get_sec}, 58);
        @(negedge clk);
        check("t2_valid_count", n_get_valid, 1);
        check("t2_err_count", n_get_err, 0);
        check("t2_busy_low", {31'd0, o_busy}, 0);
        exp_q.push_back(8'h52);
        check_tx("t2_tx");

        // Malformed separator at position 5
        pulse_get();
        wait_state(3'd4, 500, "t3_rx_entry");
        reply = "15.06/2000 10:20:30";
        for (int i = 0; i < 18; i++) begin
            send_rx(reply[i]);
            repeat (2) @(negedge clk);
        end
        check("t3_no_early_err", n_get_err, 0);
        send_rx(reply[18]);
        @(negedge clk);
        check("t3_err_pulse", {31'd0, o_get_err}, 1);
        check("t3_no_valid", {31'd0, o_get_valid}, 0);
        check("t3_date_kept", {27'd0, o_get_date}, 31);
        check("t3_year_kept", {18'd0, o_get_year}, 1999);
        check("t3_sec_kept", {26'd0, o_get_sec}, 58);
        @(negedge clk);
        check("t3_err_count", n_get_err, 1);
        check("t3_state_idle", {29'd0, o_state}, 0);
        tx_log.delete();

        // Timeout after 4 reply bytes
        pulse_get();
        wait_state(3'd4, 500, "t4_rx_entry");
        reply = "12.0";
        for (int i = 0; i < 3; i++) begin
            send_rx(reply[i]);
            repeat (2) @(negedge clk);
        end
        send_rx(reply[3]);
        c = 1;
        while (!o_get_err && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("t4_tmo_latency", c, TMO);
        @(negedge clk);
        check("t4_state_idle", {29'd0, o_state}, 0);
        check("t4_err_count", n_get_err, 2);
        check("t4_valid_count", n_get_valid, 1);
        check("t4_date_kept", {27'd0, o_get_date}, 31);
        tx_log.delete();

        // Simultaneous set+get, year clamp, get during busy ignored
        pulse_set(5'd1, 4'd1, 14'd12000, 5'd0, 6'd0, 6'd0, 1'b1);
        repeat (3) @(negedge clk);
        pulse_get();
        wait_flag(0, 1000, "t5_set_done_seen");
        repeat (30) @(negedge clk);
        check("t5_state_idle", {29'd0, o_state}, 0);
        check("t5_done_count", n_set_done, 2);
        check("t5_valid_count", n_get_valid, 1);
        check("t5_err_count", n_get_err, 2);
        push_frame(8'h4B, "01019999000000");
        check_tx("t5_tx");

        // Reset during the 8th set byte
        pulse_set(5'd7, 4'd3, 14'd2025, 5'd14, 6'd5, 6'd9, 1'b0);
        wait_flag(3, 1000, "t6_8th_byte_seen");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_busy_low", {31'd0, o_busy}, 0);
        check("t6_flag_low", {31'd0, o_flag_tx_byte}, 0);
        check("t6_state_idle", {29'd0, o_state}, 0);
        check("t6_get_date_reset", {27'd0, o_get_date}, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_tx_stopped", tx_log.size(), 8);
        check("t6_no_done", n_set_done, 2);
        tx_log.delete();
        pulse_set(5'd7, 4'd3, 14'd2025, 5'd14, 6'd5, 6'd9, 1'b0);
        wait_flag(0, 1000, "t6_restart_done");
        push_frame(8'h4B, "07032025140509");
        check_tx("t6_tx");
        check("t6_tx_overlap", tx_viol, 0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
